// File: rtl/clock_pkg.sv
// Shared types and constants for the clock datapath time-digit counters.
package clock_pkg;

  // Repeater FSM states for key hold-to-repeat
  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } rep_state_e;

  // Adjust step direction
  typedef enum logic {
    DirUp,
    DirDn
  } dir_e;

  // Default moduli for the hours and minutes/seconds digits
  localparam int unsigned HOURS_MOD  = 24;
  localparam int unsigned MINSEC_MOD = 60;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adjust_repeater.sv
// Key hold-to-repeat sequencer: first step on press, then after HOLD_CYCLES,
// then every REPEAT_CYCLES while the same single key stays held.
module adjust_repeater
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 500,
  parameter int unsigned REPEAT_CYCLES = 100
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  input  logic adj_up,
  input  logic adj_dn,
  output logic step,
  output logic step_dn
);

  localparam int unsigned MaxCyc = max_u(HOLD_CYCLES, REPEAT_CYCLES);
  // Keep at least one timer bit so degenerate 1-cycle settings still elaborate
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [TimerW-1:0] HoldLoad = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] RepLoad  = TimerW'(REPEAT_CYCLES - 1);

  rep_state_e        state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic key_valid;
  dir_e key_dir;

  // Exactly one key high is a valid press; both or neither means no key
  assign key_valid = adj_up ^ adj_dn;
  assign key_dir   = adj_dn ? DirDn : DirUp;

  // State, direction latch and timer registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      dir_q   <= DirUp;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and step pulse generation
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    step    = 1'b0;
    step_dn = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (key_valid) begin
            step    = 1'b1;
            step_dn = (key_dir == DirDn);
            dir_d   = key_dir;
            timer_d = HoldLoad;
            state_d = StHold;
          end
        end
        StHold, StRepeat: begin
          // A reversal drops to idle first, so the new direction steps one cycle later
          if (!key_valid || (key_dir != dir_q)) begin
            state_d = StIdle;
            timer_d = '0;
          end else if (timer_q == '0) begin
            step    = 1'b1;
            step_dn = (dir_q == DirDn);
            timer_d = RepLoad;
            state_d = StRepeat;
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mod_counter_adj.sv
// Modulo-N time digit with same-cycle carry, key adjust, parallel load and freeze.
module mod_counter_adj
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS       = HOURS_MOD,
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned HOLD_CYCLES   = 500,
  parameter int unsigned REPEAT_CYCLES = 100
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             tick,
  input  logic             keep,
  input  logic             adjust,
  input  logic             adj_up,
  input  logic             adj_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] value_q, value_d;
  logic             zero_q;
  logic             at_max;
  logic             rep_enable;
  logic             step;
  logic             step_dn;

  assign at_max = (value_q == MaxVal);

  // Repeater only runs when adjust actually has control of the register
  assign rep_enable = adjust & ~keep & ~load;

  adjust_repeater #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_adjust_repeater (
    .clk    (clk),
    .clear  (clear),
    .enable (rep_enable),
    .adj_up (adj_up),
    .adj_dn (adj_dn),
    .step   (step),
    .step_dn(step_dn)
  );

  // Next count: load > keep > adjust step > tick
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (load_value > MaxVal) ? MaxVal : load_value;
    end else if (keep) begin
      value_d = value_q;
    end else if (adjust) begin
      if (step) begin
        if (step_dn) begin
          value_d = (value_q == '0) ? MaxVal : value_q - WIDTH'(1);
        end else begin
          value_d = at_max ? '0 : value_q + WIDTH'(1);
        end
      end
    end else if (tick) begin
      value_d = at_max ? '0 : value_q + WIDTH'(1);
    end
  end

  // Count register with zero flag tracking it on the same edge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      value_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      value_q <= value_d;
      zero_q  <= (value_d == '0);
    end
  end

  // Carry is combinational so a cascaded stage advances on the same edge
  assign carry = tick & ~keep & ~adjust & ~load & at_max;
  assign value = value_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_mod_counter_adj.sv
// Directed self-checking bench for mod_counter_adj, plus a 60x60 cascade.
module tb_mod_counter_adj;

  logic       clk = 1'b0;
  logic       clear;
  logic       tick, keep, adjust, adj_up, adj_dn, load;
  logic [5:0] load_value;
  logic [5:0] value;
  logic       carry, zero;

  logic       tick_c;
  logic [5:0] val_lo, val_hi;
  logic       carry_lo, carry_hi, zero_lo, zero_hi;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_counter_adj u_dut (
    .clk       (clk),
    .clear     (clear),
    .tick      (tick),
    .keep      (keep),
    .adjust    (adjust),
    .adj_up    (adj_up),
    .adj_dn    (adj_dn),
    .load      (load),
    .load_value(load_value),
    .value     (value),
    .carry     (carry),
    .zero      (zero)
  );

  mod_counter_adj #(.MODULUS(60), .WIDTH(6)) u_lo (
    .clk       (clk),
    .clear     (clear),
    .tick      (tick_c),
    .keep      (1'b0),
    .adjust    (1'b0),
    .adj_up    (1'b0),
    .adj_dn    (1'b0),
    .load      (1'b0),
    .load_value(6'd0),
    .value     (val_lo),
    .carry     (carry_lo),
    .zero      (zero_lo)
  );

  mod_counter_adj #(.MODULUS(60), .WIDTH(6)) u_hi (
    .clk       (clk),
    .clear     (clear),
    .tick      (carry_lo),
    .keep      (1'b0),
    .adjust    (1'b0),
    .adj_up    (1'b0),
    .adj_dn    (1'b0),
    .load      (1'b0),
    .load_value(6'd0),
    .value     (val_hi),
    .carry     (carry_hi),
    .zero      (zero_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    clear = 1'b1; tick = 1'b0; keep = 1'b0; adjust = 1'b0;
    adj_up = 1'b0; adj_dn = 1'b0; load = 1'b0; load_value = '0; tick_c = 1'b0;

    // Reset state
    #2;
    check("rst_value", 32'(value), 0);
    check("rst_zero", 32'(zero), 1);
    check("rst_carry", 32'(carry), 0);
    next_edge();
    check("rst_hold_value", 32'(value), 0);
    clear = 1'b0;

    // 24 ticks: full count and wrap, carry only at 23
    tick = 1'b1;
    for (int i = 0; i < 24; i++) begin
      #1;
      check("cnt_value", 32'(value), 32'(i));
      check("cnt_carry", 32'(carry), 32'(i == 23));
      check("cnt_zero", 32'(zero), 32'(i == 0));
      next_edge();
    end
    tick = 1'b0;
    check("wrap_value", 32'(value), 0);
    check("wrap_zero", 32'(zero), 1);

    // Step down at 0 wraps to 23 without carry
    adjust = 1'b1;
    adj_dn = 1'b1;
    #1;
    check("adj_dn_carry", 32'(carry), 0);
    next_edge();
    adj_dn = 1'b0;
    check("adj_dn_wrap", 32'(value), 23);
    tick = 1'b1;
    #1;
    check("adj_tick_carry", 32'(carry), 0);
    next_edge();
    check("adj_tick_ignored", 32'(value), 23);
    tick = 1'b0;

    // Hold up for 700 edges: steps at edges 0, 500, 600
    adj_up = 1'b1;
    for (int e = 0; e < 700; e++) begin
      next_edge();
      check("hold_repeat", 32'(value), (e < 500) ? 0 : (e < 600) ? 1 : 2);
    end
    adj_up = 1'b0;
    next_edge();
    check("release", 32'(value), 2);

    // Both keys high: no step
    adj_up = 1'b1;
    adj_dn = 1'b1;
    repeat (5) next_edge();
    check("both_keys", 32'(value), 2);

    // Freeze with up held, then release freeze: one step on next edge
    adj_dn = 1'b0;
    keep = 1'b1;
    repeat (10) next_edge();
    check("keep_adj", 32'(value), 2);
    keep = 1'b0;
    next_edge();
    check("keep_release_step", 32'(value), 3);
    next_edge();
    check("keep_release_hold", 32'(value), 3);
    adj_up = 1'b0;
    next_edge();

    // Normal mode ignores keys
    adjust = 1'b0;
    adj_up = 1'b1;
    repeat (3) next_edge();
    check("norm_keys_ignored", 32'(value), 3);
    adj_up = 1'b0;

    // Load saturates, keep blocks tick and carry, load beats tick
    load = 1'b1;
    load_value = 6'd30;
    next_edge();
    load = 1'b0;
    check("load_sat", 32'(value), 23);
    keep = 1'b1;
    tick = 1'b1;
    #1;
    check("keep_carry", 32'(carry), 0);
    next_edge();
    check("keep_hold", 32'(value), 23);
    keep = 1'b0;
    #1;
    check("carry_at_max", 32'(carry), 1);
    load = 1'b1;
    load_value = 6'd5;
    #1;
    check("load_carry", 32'(carry), 0);
    next_edge();
    check("load_over_tick", 32'(value), 5);
    load = 1'b0;
    tick = 1'b0;

    // Adjust falling mid-hold lets tick count on the same edge
    adjust = 1'b1;
    adj_dn = 1'b1;
    next_edge();
    check("dn_step", 32'(value), 4);
    next_edge();
    check("dn_hold", 32'(value), 4);
    adjust = 1'b0;
    tick = 1'b1;
    #1;
    check("adj_fall_carry", 32'(carry), 0);
    next_edge();
    check("adj_fall_tick", 32'(value), 5);
    tick = 1'b0;
    adjust = 1'b1;
    next_edge();
    check("readj_step", 32'(value), 4);

    // Direction reversal: one idle cycle, then one step the other way
    adj_dn = 1'b0;
    adj_up = 1'b1;
    next_edge();
    check("rev_idle", 32'(value), 4);
    next_edge();
    check("rev_step", 32'(value), 5);
    next_edge();
    check("rev_hold", 32'(value), 5);

    // Into REPEAT (step at 500 edges after rev_step), then async clear
    repeat (510) next_edge();
    check("rep_before_clear", 32'(value), 6);
    #2;
    clear = 1'b1;
    #1;
    check("clr_value", 32'(value), 0);
    check("clr_zero", 32'(zero), 1);
    check("clr_carry", 32'(carry), 0);
    next_edge();
    #3;
    clear = 1'b0;
    next_edge();
    check("post_clear_step", 32'(value), 1);
    next_edge();
    check("post_clear_hold", 32'(value), 1);
    adj_up = 1'b0;
    adjust = 1'b0;

    // Cascade of two modulo-60 stages
    check("casc_start", 32'({val_hi, val_lo}), 0);
    tick_c = 1'b1;
    for (int i = 0; i < 3600; i++) begin
      #1;
      if ((i % 60) == 59) check("casc_carry_lo", 32'(carry_lo), 1);
      if ((i % 60) == 0) check("casc_no_carry_lo", 32'(carry_lo), 0);
      next_edge();
      if ((i % 60) == 59) begin
        check("casc_lo_wrap", 32'(val_lo), 0);
        check("casc_hi_adv", 32'(val_hi), 32'(((i + 1) / 60) % 60));
      end
    end
    tick_c = 1'b0;
    check("casc_final_lo", 32'(val_lo), 0);
    check("casc_final_hi", 32'(val_hi), 0);
    check("casc_final_zero", 32'({zero_hi, zero_lo}), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter_adj.md
# mod_counter_adj

Parametrised modulo-N time-digit counter with synchronous adjust, replacing the fixed hours/minutes/seconds counters of the clock datapath. Counts `tick` pulses modulo `MODULUS`, emits a same-cycle `carry` for cascading stages on one clock, and supports user setting via up/down keys with hold-to-repeat, parallel load and freeze. All logic runs on `clk`; there is no gated or merged clock.

## Interface
- `MODULUS`, 24: count range 0..MODULUS-1; legal values 2..2**WIDTH.
- `WIDTH`, 6: width of `value`/`load_value`.
- `HOLD_CYCLES`, 500: clocks a key must be held before auto-repeat; ≥1.
- `REPEAT_CYCLES`, 100: clocks between auto-repeat steps; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-cycle count enable from the lower stage or timebase.
- `keep`  in  1  freeze: no count, no adjust step.
- `adjust`  in  1  setting mode; `tick` is ignored while high.
- `adj_up`  in  1  debounced up key, level.
- `adj_dn`  in  1  debounced down key, level.
- `load`  in  1  synchronous parallel load.
- `load_value`  in  WIDTH  value for `load`.
- `value`  out  WIDTH  current count, registered.
- `carry`  out  1  combinational wrap indication for the next stage's `tick`.
- `zero`  out  1  `value == 0`, registered-derived.

## Operation
- Priority per clock edge: `load` > `keep` > `adjust` steps > `tick` counting.
- `load`: `value <= min(load_value, MODULUS-1)`; repeater FSM forced to IDLE.
- `keep=1`: `value` holds; FSM forced to IDLE; `carry=0`.
- Normal mode (`adjust=0`): on `tick`, `value==MODULUS-1` → 0, else +1. Key inputs ignored; FSM held IDLE.
- `carry = tick & !keep & !adjust & !load & (value==MODULUS-1)`. Adjust-mode wraps never raise `carry`.
- Adjust mode: direction `dir` is valid when exactly one of `adj_up`/`adj_dn` is high; both high or both low = no key.
- Step up: MODULUS-1 → 0, else +1. Step down: 0 → MODULUS-1, else −1.
- Repeater FSM, timer width `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES))`:
  - IDLE: valid key → step once, latch direction, timer = HOLD_CYCLES-1, go to HOLD.
  - HOLD: key released, invalid, or direction differs → IDLE with no step. Timer==0 → step, timer = REPEAT_CYCLES-1, go to REPEAT. Otherwise decrement.
  - REPEAT: same exit rule as HOLD; timer==0 → step and reload REPEAT_CYCLES-1.
- Direction reversal while held: IDLE for one cycle, then steps once in the new direction.
- `adjust` falling mid-hold: FSM goes to IDLE; the same edge may count `tick`.

## Timing
- Reset (`clear` high, asynchronous): `value=0`, `zero=1`, `carry=0`, FSM IDLE, timer 0. Release is synchronous to `clk` by the system reset bridge.
- `tick` → `value` update: 1 edge. `carry` is valid in the same cycle as the wrapping `tick`, so a cascaded stage advances on the same edge.
- Key press → first step: the edge on which the key is first sampled valid.
- Second step: HOLD_CYCLES edges after the first. Each later step: REPEAT_CYCLES edges after the previous one.
- `zero` follows `value` on the same edge.

## Structure
- Shared package `clock_pkg`:
  - repeater state enum (IDLE, HOLD, REPEAT);
  - direction enum (UP, DN);
  - default constants HOURS_MOD=24, MINSEC_MOD=60.
- Sub-module `adjust_repeater`: FSM, timer and direction latch. It outputs `step` and `step_dn` pulses. The top level owns the count register, priority and `carry`.

## Test plan
- Default params, reset, then 24 `tick` pulses → `value` 0..23..0; `carry=1` only in the cycle with `value=23` and `tick=1`; `zero=1` after wrap.
- MODULUS=60, two instances cascaded via `carry`→`tick` → after 3600 ticks both read 0; upper stage increments on the same edge as the lower wrap.
- `adjust=1`, `adj_dn` pulsed 1 cycle at `value=0` → `value=23`, no `carry`. `adj_up` held 700 cycles (HOLD=500, REPEAT=100) → 3 steps, at cycles 0, 500 and 600.
- Both keys high, or `keep=1` while `adj_up` is held → `value` unchanged, FSM IDLE. Release `keep` with `adj_up` still held → one step on the next edge.
- `load` with `load_value=30` at MODULUS=24 → `value=23`. `load` and `tick` together at `value=23` → `value=load_value`, `carry=0`.
- `clear` asserted mid-REPEAT, asynchronously between edges → `value=0`, `zero=1` immediately. After release with the key still held → a step occurs only from IDLE on the next edge.
